// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, state encodings and iteration constants for muldiv
package muldiv_pkg;

    localparam logic [1:0] MULDIV_OP_MULT  = 2'd0;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'd1;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'd2;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'd3;

    localparam int MULDIV_ITER  = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_ITER);

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_PREP = 2'd1,
        MULDIV_CALC = 2'd2,
        MULDIV_FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - two's-complement conditional negate
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    // Pass-through or two's-complement negation, selected by neg
    always_comb begin
        y = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    end

endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t state, next_state;

    // Latched operation context
    logic [WIDTH-1:0]        a_q, b_q;
    logic                    sign_a, sign_b;
    logic                    is_div;
    logic                    b_zero;

    // Datapath: acc holds the product for multiplies, {remainder, quotient} for divides
    logic [2*WIDTH-1:0]      acc;
    logic [WIDTH-1:0]        opb;
    logic [MULDIV_CNT_W-1:0] cnt;

    logic                    accept;
    logic                    fix_we;
    logic                    signed_op;

    logic [WIDTH-1:0]        abs_a, abs_b;
    logic [WIDTH:0]          r_shift;
    logic                    r_ge;
    logic [WIDTH-1:0]        r_sub;
    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      div_step, mul_step;

    logic [2*WIDTH-1:0]      res_in, res_out;
    logic                    res_neg;
    logic [WIDTH-1:0]        rem_out;
    logic [WIDTH-1:0]        fix_hi, fix_lo;

    // Operand magnitudes; the sign flags are zero for unsigned ops
    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(sign_a), .x(a_q), .y(abs_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(sign_b), .x(b_q), .y(abs_b));

    // Result sign correction: full product or quotient in the low half, remainder separately
    muldiv_negate #(.WIDTH(2*WIDTH)) u_res (.neg(res_neg), .x(res_in), .y(res_out));
    muldiv_negate #(.WIDTH(WIDTH))   u_rem (.neg(sign_a), .x(acc[2*WIDTH-1:WIDTH]), .y(rem_out));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MULDIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; cancel aborts any non-idle state
    always_comb begin
        next_state = state;
        if (state != MULDIV_IDLE && cancel) begin
            next_state = MULDIV_IDLE;
        end else begin
            case (state)
                MULDIV_IDLE: if (start) next_state = MULDIV_PREP;
                MULDIV_PREP: begin
`ifdef MULDIV_FAST_MUL_EN
                    next_state = is_div ? MULDIV_CALC : MULDIV_FIX;
`else
                    next_state = MULDIV_CALC;
`endif
                end
                MULDIV_CALC: if (cnt == '0) next_state = MULDIV_FIX;
                MULDIV_FIX:  next_state = MULDIV_IDLE;
                default:     next_state = MULDIV_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the state register
    always_comb begin
        busy   = (state != MULDIV_IDLE);
        accept = (state == MULDIV_IDLE) && start;
        fix_we = (state == MULDIV_FIX) && !cancel;
    end

    // One iteration of restoring division and shift-add multiplication
    always_comb begin
        signed_op = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
        r_shift   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        r_ge      = (r_shift >= {1'b0, opb});
        r_sub     = r_shift[WIDTH-1:0] - opb;
        div_step  = r_ge ? {r_sub, acc[WIDTH-2:0], 1'b1}
                         : {r_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_step  = {mul_sum, acc[WIDTH-1:1]};
    end

    // Final result assembly; a zero divisor keeps the all-ones quotient unsigned
    always_comb begin
        res_in  = is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
        res_neg = is_div ? ((sign_a ^ sign_b) && !b_zero) : (sign_a ^ sign_b);
        fix_hi  = is_div ? rem_out : res_out[2*WIDTH-1:WIDTH];
        fix_lo  = res_out[WIDTH-1:0];
    end

    // Operand latch, datapath load and iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            b_zero <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                MULDIV_IDLE: begin
                    if (accept) begin
                        a_q    <= a;
                        b_q    <= b;
                        sign_a <= signed_op && a[WIDTH-1];
                        sign_b <= signed_op && b[WIDTH-1];
                        is_div <= (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
                        b_zero <= (b == '0);
                    end
                end
                MULDIV_PREP: begin
                    opb <= abs_b;
                    cnt <= MULDIV_CNT_W'(MULDIV_ITER - 1);
`ifdef MULDIV_FAST_MUL_EN
                    if (is_div) begin
                        acc <= {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        acc <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                    end
`else
                    acc <= {{WIDTH{1'b0}}, abs_a};
`endif
                end
                MULDIV_CALC: begin
                    cnt <= cnt - 1'b1;
                    acc <= is_div ? div_step : mul_step;
                end
                default: begin
                end
            endcase
        end
    end

    // HI/LO writeback from FIX or from MTHI/MTLO while idle, plus the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix_we;
            if (fix_we) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (state == MULDIV_IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule
